// File: rtl/seg7_display_driver_if.sv
// ============================================================================
// Module   : seg7_display_driver_if
// Brief    : Load/value/blank inputs and segment outputs of the 7-seg driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seg7_display_driver_if #(
  parameter int N_DIGITS = 6
);
  logic                  load_i;
  logic [4*N_DIGITS-1:0] value_i;
  logic [N_DIGITS-1:0]   blink_i;
  logic [N_DIGITS-1:0]   dp_i;
  logic                  lzb_i;
  logic                  blank_i;
  logic [8*N_DIGITS-1:0] hex_o;

  modport master (
    output load_i, value_i, blink_i, dp_i, lzb_i, blank_i,
    input  hex_o
  );

  modport slave (
    input  load_i, value_i, blink_i, dp_i, lzb_i, blank_i,
    output hex_o
  );
endinterface

`default_nettype wire

// File: rtl/seg7_display_driver.sv
// ============================================================================
// Module   : seg7_display_driver
// Brief    : Registered hex 7-segment driver with LZB, blinking and blanking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_display_driver #(
  parameter int N_DIGITS   = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  seg7_display_driver_if.slave    bus
);

  localparam int c_cnt_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BLINK_DIV - 1);
  localparam bit c_inv = (ACTIVE_LOW != 0);
  localparam logic [8*N_DIGITS-1:0] c_off = c_inv ? {8*N_DIGITS{1'b1}} : {8*N_DIGITS{1'b0}};

  logic [4*N_DIGITS-1:0] r_value;
  logic [N_DIGITS-1:0]   r_blink;
  logic [N_DIGITS-1:0]   r_dp;
  logic                  r_lzb;
  logic                  r_loaded;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_phase;
  logic [8*N_DIGITS-1:0] r_hex;
  logic [8*N_DIGITS-1:0] w_on;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Latched display state; r_loaded keeps the pins dark until the first load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value  <= '0;
      r_blink  <= '0;
      r_dp     <= '0;
      r_lzb    <= 1'b0;
      r_loaded <= 1'b0;
    end else if (bus.load_i) begin
      r_value  <= bus.value_i;
      r_blink  <= bus.blink_i;
      r_dp     <= bus.dp_i;
      r_lzb    <= bus.lzb_i;
      r_loaded <= 1'b1;
    end
  end

  // Load restarts the blink cycle in the on phase and overrides a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (bus.load_i) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Walk from the most significant digit down so the zero run is known per digit.
  always_comb begin
    logic       w_zero_run;
    logic [3:0] w_nib;
    logic [7:0] w_byte;
    w_on       = '0;
    w_zero_run = 1'b1;
    w_nib      = '0;
    w_byte     = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_nib      = r_value[4*i +: 4];
      w_zero_run = w_zero_run & (w_nib == 4'h0);
      w_byte     = {r_dp[i], f_decode(w_nib)};
      if (r_lzb && w_zero_run && (i > 0))
        w_byte = 8'h00;
      if (r_blink[i] && !r_phase)
        w_byte = 8'h00;
      w_on[8*i +: 8] = w_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_hex <= c_off;
    else if (bus.blank_i || !r_loaded)
      r_hex <= c_off;
    else
      r_hex <= c_inv ? ~w_on : w_on;
  end

  assign bus.hex_o = r_hex;

endmodule

`default_nettype wire

// File: tb/tb_seg7_display_driver.sv
// ============================================================================
// Module   : tb_seg7_display_driver
// Brief    : Directed vector bench for seg7_display_driver (4 digits, div 4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_display_driver;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  seg7_display_driver_if #(.N_DIGITS(4)) bus ();

  seg7_display_driver #(
    .N_DIGITS   (4),
    .BLINK_DIV  (4),
    .ACTIVE_LOW (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  blink;
    logic [3:0]  dp;
    logic        lzb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Load on one edge, then return at the negedge after the following edge.
  task automatic do_load(input logic [15:0] value, input logic [3:0] blink,
                         input logic [3:0] dp, input logic lzb);
    @(negedge clk);
    bus.value_i = value;
    bus.blink_i = blink;
    bus.dp_i    = dp;
    bus.lzb_i   = lzb;
    bus.load_i  = 1'b1;
    @(negedge clk);
    bus.load_i  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{16'h12AB, 4'h0, 4'h0,    1'b0, 32'hF9A4_8883};
    vecs[1]  = '{16'h0123, 4'h0, 4'h0,    1'b0, 32'hC0F9_A4B0};
    vecs[2]  = '{16'h4567, 4'h0, 4'h0,    1'b0, 32'h9992_82F8};
    vecs[3]  = '{16'h89AB, 4'h0, 4'h0,    1'b0, 32'h8090_8883};
    vecs[4]  = '{16'hCDEF, 4'h0, 4'h0,    1'b0, 32'hC6A1_868E};
    vecs[5]  = '{16'h0123, 4'h0, 4'b1010, 1'b0, 32'h40F9_24B0};
    vecs[6]  = '{16'h0050, 4'h0, 4'b0100, 1'b1, 32'hFFFF_92C0};
    vecs[7]  = '{16'h0000, 4'h0, 4'h0,    1'b1, 32'hFFFF_FFC0};
    vecs[8]  = '{16'h0050, 4'h0, 4'b0010, 1'b1, 32'hFFFF_12C0};
    vecs[9]  = '{16'h0102, 4'h0, 4'h0,    1'b1, 32'hFFF9_C0A4};
    vecs[10] = '{16'h0000, 4'h0, 4'b0001, 1'b1, 32'hFFFF_FF40};
    vecs[11] = '{16'h0000, 4'h0, 4'h0,    1'b0, 32'hC0C0_C0C0};
    vecs[12] = '{16'hF000, 4'h0, 4'h0,    1'b1, 32'h8EC0_C0C0};

    bus.load_i  = 1'b0;
    bus.value_i = '0;
    bus.blink_i = '0;
    bus.dp_i    = '0;
    bus.lzb_i   = 1'b0;
    bus.blank_i = 1'b0;
    rst_n       = 1'b1;

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1 check("reset_async", bus.hex_o, 32'hFFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_noload", bus.hex_o, 32'hFFFF_FFFF);

    for (int v = 0; v < 13; v++) begin
      do_load(vecs[v].value, vecs[v].blink, vecs[v].dp, vecs[v].lzb);
      check($sformatf("vec%0d", v), bus.hex_o, vecs[v].exp);
    end

    // Global blank for exactly one cycle
    do_load(16'h12AB, 4'h0, 4'h0, 1'b0);
    check("blank_pre", bus.hex_o, 32'hF9A4_8883);
    bus.blank_i = 1'b1;
    @(negedge clk);
    check("blank_on", bus.hex_o, 32'hFFFF_FFFF);
    bus.blank_i = 1'b0;
    @(negedge clk);
    check("blank_off", bus.hex_o, 32'hF9A4_8883);

    // Blink: 4 on, 4 off, repeating
    do_load(16'h0007, 4'b0001, 4'h0, 1'b0);
    for (int j = 0; j < 14; j++) begin
      check($sformatf("blink_%0d", j), bus.hex_o,
            (((j / 4) % 2) == 0) ? 32'hC0C0_C0F8 : 32'hC0C0_C0FF);
      if (j < 13) @(negedge clk);
    end
    // Reload while off: on again after the latency, with a fresh 4-cycle on phase
    bus.load_i = 1'b1;
    @(negedge clk);
    bus.load_i = 1'b0;
    check("reload_lat", bus.hex_o, 32'hC0C0_C0FF);
    for (int m = 0; m < 5; m++) begin
      @(negedge clk);
      check($sformatf("reload_%0d", m), bus.hex_o,
            (m < 4) ? 32'hC0C0_C0F8 : 32'hC0C0_C0FF);
    end

    // Reset in the middle of blinking
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midreset_async", bus.hex_o, 32'hFFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_hold", bus.hex_o, 32'hFFFF_FFFF);
    do_load(16'h12AB, 4'h0, 4'h0, 1'b0);
    check("midreset_load", bus.hex_o, 32'hF9A4_8883);
    repeat (6) @(negedge clk);
    check("midreset_noblink", bus.hex_o, 32'hF9A4_8883);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
